sap1_controller: RTL and testbench
==================================

# sap1_controller

Fetch/execute controller and datapath for the 8-bit SAP-1 machine. It is the reading side of the 16×8 program memory: it drives the memory's 4-bit address and active-low enable `CE_barra`, captures the 8-bit word `W`, and executes LDA/ADD/SUB/OUT/HLT. It sits between the program memory and the output display register.

## Interface
- `ADDR_W`, default 4: memory address width. PC and MAR are this wide.
- `DATA_W`, default 8: word width. IR, A, B and OUT are this wide.
- `clk` input, 1: single system clock. All state updates on the rising edge.
- `rst` input, 1: **synchronous, active-high reset**.
- `address` output, ADDR_W: memory address, driven directly from MAR.
- `CE_barra` output, 1: memory enable, active low. Decoded combinationally from state and opcode.
- `W` input, DATA_W: memory data. It is high-Z whenever `CE_barra`=1.
- `out_reg` output, DATA_W: OUT register.
- `acc` output, DATA_W: accumulator A, exposed for verification.
- `t_state` output, 6: one-hot ring counter, T1=bit0 … T6=bit5.
- `halted` output, 1: high once HLT has executed.

## Operation
- Registers: PC, MAR, IR[7:4]=opcode, IR[3:0]=operand, A, B, OUT.
- Opcodes:
  - LDA=0000
  - ADD=0001
  - SUB=0010
  - OUT=1110
  - HLT=1111
  - Every other opcode is a NOP.
- Every instruction takes exactly six cycles, T1→T6→T1.
- T1: MAR ← PC.
- T2: PC ← PC+1, modulo 2^ADDR_W, so 15 wraps to 0.
- T3: `CE_barra`=0; IR ← W.
- T4:
  - LDA/ADD/SUB: MAR ← IR[3:0].
  - OUT: OUT ← A.
  - HLT: enter HALT.
  - NOP: idle.
- T5:
  - LDA: `CE_barra`=0; A ← W.
  - ADD/SUB: `CE_barra`=0; B ← W.
  - Others: idle, `CE_barra`=1.
- T6:
  - ADD: A ← A+B, modulo 256, carry discarded.
  - SUB: A ← A−B, modulo 256, two's complement wrap.
  - Others: idle.
- `CE_barra`=1 in every state not listed above, so W is never sampled while high-Z.
- HALT:
  - Terminal state. `t_state`=000000, `halted`=1, `CE_barra`=1.
  - All registers hold. Only `rst` exits HALT.
- W may contain X bits in its low nibble for OUT/HLT words. These are captured into IR[3:0] and must not affect behaviour.

## Timing
- Reset, at the first edge with `rst`=1:
  - PC=MAR=IR=A=B=OUT=0.
  - `t_state`=000001 (T1), `halted`=0.
  - Resulting outputs: `address`=0, `CE_barra`=1, `out_reg`=0, `acc`=0.
- Reset has priority over every state, including HALT and mid-instruction T2–T6. Any partial instruction is abandoned.
- Edge numbering: edge 1 is the first rising edge with `rst`=0. Edge 1 ends T1.
- Instruction k (0-based) occupies edges 6k+1 … 6k+6.
- Memory reads:
  - The memory is combinational: W is valid in the same cycle that `address` and `CE_barra`=0 are presented.
  - W is captured at the edge that ends T3 (and T5 where applicable).
  - `address` is stable for the whole enabled cycle because MAR changes only at T1/T4 edges.
- Result latency:
  - A updates at the end of T5 (LDA) or T6 (ADD/SUB).
  - OUT updates at the end of T4.
  - `halted` rises at the end of T4 of HLT.

## Test plan
- Reset values: hold `rst` for 2 cycles with arbitrary W → `address`=0, `CE_barra`=1, `out_reg`=0, `acc`=0, `t_state`=000001, `halted`=0.
- Reference program:
  - Memory: 0:0x06, 1:0x17, 2:0x18, 3:0x29, 4:0xE0, 5:0xF0, 6:0x01, 7:0x03, 8:0x02, 9:0x03.
  - Required `acc` after edges 5/12/18/24: 1/4/6/3.
  - `out_reg`=0x03 after edge 28.
  - `halted`=1 after edge 34.
  - `CE_barra`=1 and all outputs frozen for the next 100 cycles.
- SUB underflow: LDA of 0x01, then SUB of 0x03 → `acc`=0xFE; ADD 0xFF+0x02 → 0x01.
- PC wrap and NOP:
  - Memory filled with 0x70.
  - `address` during T3 steps 0,1,…,15,0.
  - `CE_barra` is low only in T3, never in T5.
  - `acc` stays 0.
- Reset mid-operation: assert `rst` for one cycle during T5 of LDA 0x06 (data 0x55) → `acc` stays 0, next state T1, `address`=0, execution restarts from PC=0.
- Reset from HALT: after `halted`=1, pulse `rst` → `halted`=0 and the program re-runs with identical timing.

Source files
------------

// File: rtl/sap1_controller.sv
// SAP-1 fetch/execute controller and datapath: reads 16x8 program memory, runs LDA/ADD/SUB/OUT/HLT.
// Latency: six cycles per instruction (T1..T6); A updates at end of T5/T6, OUT at end of T4.
// Backpressure: none; memory is combinational and always ready, HALT freezes everything until rst.
module sap1_controller #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] address,
   output logic              CE_barra,
   input  logic [DATA_W-1:0] W,
   output logic [DATA_W-1:0] out_reg,
   output logic [DATA_W-1:0] acc,
   output logic [5:0]        t_state,
   output logic              halted
);

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [2:0] {
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_HALT
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] out_q;

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic              mem_op;

   // Only the opcode nibble steers control; the operand nibble may hold X for OUT/HLT.
   assign opcode  = ir[DATA_W-1 -: 4];
   assign operand = ir[ADDR_W-1:0];
   assign mem_op  = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);

   assign address = mar;
   assign out_reg = out_q;
   assign acc     = a_reg;

   // Memory is enabled only for the instruction fetch (T3) and the operand read (T5 of LDA/ADD/SUB).
   always_comb begin
      CE_barra = 1'b1;
      if (state == S_T3) begin
         CE_barra = 1'b0;
      end else if (state == S_T5 && mem_op) begin
         CE_barra = 1'b0;
      end
   end

   // Ring-counter FSM with datapath register transfers; reset overrides every state including HALT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_T1;
         t_state <= 6'b000001;
         halted  <= 1'b0;
         pc      <= '0;
         mar     <= '0;
         ir      <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         out_q   <= '0;
      end else begin
         case (state)
            S_T1: begin
               mar     <= pc;
               state   <= S_T2;
               t_state <= 6'b000010;
            end
            S_T2: begin
               pc      <= pc + ADDR_W'(1);
               state   <= S_T3;
               t_state <= 6'b000100;
            end
            S_T3: begin
               ir      <= W;
               state   <= S_T4;
               t_state <= 6'b001000;
            end
            S_T4: begin
               if (opcode == OP_HLT) begin
                  state   <= S_HALT;
                  t_state <= 6'b000000;
                  halted  <= 1'b1;
               end else begin
                  if (mem_op) begin
                     mar <= operand;
                  end else if (opcode == OP_OUT) begin
                     out_q <= a_reg;
                  end
                  state   <= S_T5;
                  t_state <= 6'b010000;
               end
            end
            S_T5: begin
               if (opcode == OP_LDA) begin
                  a_reg <= W;
               end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                  b_reg <= W;
               end
               state   <= S_T6;
               t_state <= 6'b100000;
            end
            S_T6: begin
               // Both add and subtract wrap modulo 2^DATA_W; carry/borrow is dropped.
               if (opcode == OP_ADD) begin
                  a_reg <= a_reg + b_reg;
               end else if (opcode == OP_SUB) begin
                  a_reg <= a_reg - b_reg;
               end
               state   <= S_T1;
               t_state <= 6'b000001;
            end
            S_HALT: begin
               state   <= S_HALT;
               t_state <= 6'b000000;
               halted  <= 1'b1;
            end
            default: begin
               state   <= S_T1;
               t_state <= 6'b000001;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller: program table, random programs, reset corner cases.
// Reference is an instruction-level model; per-cycle outputs derived from the phase rules.
// Memory model answers combinationally; junk data is driven whenever the enable is high.
module tb_sap1_controller;

   logic       clk;
   logic       rst;
   logic [3:0] address;
   logic       CE_barra;
   logic [7:0] W;
   logic [7:0] out_reg;
   logic [7:0] acc;
   logic [5:0] t_state;
   logic       halted;

   logic [7:0] mem [16];
   logic [7:0] junk;

   int n_cmp  = 0;
   int n_fail = 0;

   sap1_controller #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .address  (address),
      .CE_barra (CE_barra),
      .W        (W),
      .out_reg  (out_reg),
      .acc      (acc),
      .t_state  (t_state),
      .halted   (halted)
   );

   assign W = CE_barra ? junk : mem[address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] prog;
      int           max_instr;
      logic [7:0]   exp_acc;
      logic [7:0]   exp_out;
      bit           exp_halt;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      junk = 8'($urandom);
   endtask

   task automatic load(input logic [127:0] prog);
      for (int i = 0; i < 16; i++) mem[i] = prog[i*8 +: 8];
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) step();
      rst = 1'b0;
      chk("rst_address", 32'(address), 32'h0);
      chk("rst_ce", 32'(CE_barra), 32'h1);
      chk("rst_out", 32'(out_reg), 32'h0);
      chk("rst_acc", 32'(acc), 32'h0);
      chk("rst_t", 32'(t_state), 32'h1);
      chk("rst_halted", 32'(halted), 32'h0);
   endtask

   // Runs from reset using an instruction-level model; checks every cycle.
   task automatic run_prog(input int rst_cycles, input int max_instr,
                           output logic [7:0] fa, output logic [7:0] fo, output bit fh);
      logic [3:0] m_pc, m_mar, fetch, opr;
      logic [7:0] m_a, m_out, new_a, new_out, ir;
      logic [3:0] op;
      bit         m_h, memop;
      int         a_phase;
      do_reset(rst_cycles);
      m_pc = 0; m_mar = 0; m_a = 0; m_out = 0; m_h = 0;
      for (int k = 0; k < max_instr && !m_h; k++) begin
         fetch = m_pc;
         ir    = mem[fetch];
         op    = ir[7:4];
         opr   = ir[3:0];
         memop = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
         case (op)
            4'h0:    new_a = mem[opr];
            4'h1:    new_a = m_a + mem[opr];
            4'h2:    new_a = m_a - mem[opr];
            default: new_a = m_a;
         endcase
         a_phase = (op == 4'h0) ? 5 : 6;
         new_out = (op == 4'hE) ? m_a : m_out;
         for (int p = 1; p <= 6; p++) begin
            logic [5:0] e_t;
            logic       e_ce;
            logic [3:0] e_addr;
            if (op == 4'hF && p > 4) break;
            e_t    = 6'b1 << (p - 1);
            e_ce   = !(p == 3 || (p == 5 && memop));
            e_addr = (p == 1) ? m_mar : ((p >= 5 && memop) ? opr : fetch);
            chk("t_state", 32'(t_state), 32'(e_t));
            chk("ce_barra", 32'(CE_barra), 32'(e_ce));
            chk("address", 32'(address), 32'(e_addr));
            chk("acc", 32'(acc), 32'((p > a_phase) ? new_a : m_a));
            chk("out_reg", 32'(out_reg), 32'((p > 4) ? new_out : m_out));
            chk("halted", 32'(halted), 32'h0);
            step();
         end
         m_a   = new_a;
         m_out = new_out;
         m_mar = memop ? opr : fetch;
         m_pc  = fetch + 4'd1;
         if (op == 4'hF) m_h = 1;
      end
      if (m_h) begin
         for (int c = 0; c < 100; c++) begin
            chk("halt_t", 32'(t_state), 32'h0);
            chk("halt_ce", 32'(CE_barra), 32'h1);
            chk("halt_flag", 32'(halted), 32'h1);
            chk("halt_acc", 32'(acc), 32'(m_a));
            chk("halt_out", 32'(out_reg), 32'(m_out));
            chk("halt_addr", 32'(address), 32'(m_mar));
            step();
         end
      end else begin
         chk("end_t", 32'(t_state), 32'h1);
         chk("end_acc", 32'(acc), 32'(m_a));
      end
      fa = m_a; fo = m_out; fh = m_h;
   endtask

   initial begin
      logic [7:0]   fa, fo;
      bit           fh;
      logic [127:0] rp;

      vecs[0] = '{128'h0000_0000_0000_0302_0301_F0E0_2918_1706, 10, 8'h03, 8'h03, 1'b1};
      vecs[1] = '{128'h0000_0000_0301_0000_0000_0000_F0E0_2B0A, 10, 8'hFE, 8'hFE, 1'b1};
      vecs[2] = '{128'h0000_0000_02FF_0000_0000_0000_F0E0_1B0A, 10, 8'h01, 8'h01, 1'b1};
      vecs[3] = '{{16{8'h70}},                               17, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{128'h0000_0000_0000_0000_0000_4200_F9E7_3C05, 10, 8'h42, 8'h42, 1'b1};

      rst  = 1'b1;
      junk = 8'hA5;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;

      for (int v = 0; v < 5; v++) begin
         load(vecs[v].prog);
         run_prog(2, vecs[v].max_instr, fa, fo, fh);
         chk("vec_acc", 32'(fa), 32'(vecs[v].exp_acc));
         chk("vec_out", 32'(fo), 32'(vecs[v].exp_out));
         chk("vec_halt", 32'(fh), 32'(vecs[v].exp_halt));
      end

      // Reference program explicit milestones: acc after edges 5/12/18/24, out after 28, halted after 34.
      load(vecs[0].prog);
      do_reset(2);
      for (int e = 1; e <= 34; e++) begin
         step();
         if (e == 5)  chk("ref_acc_e5", 32'(acc), 32'h01);
         if (e == 12) chk("ref_acc_e12", 32'(acc), 32'h04);
         if (e == 18) chk("ref_acc_e18", 32'(acc), 32'h06);
         if (e == 24) chk("ref_acc_e24", 32'(acc), 32'h03);
         if (e == 28) chk("ref_out_e28", 32'(out_reg), 32'h03);
         if (e == 33) chk("ref_halt_e33", 32'(halted), 32'h0);
         if (e == 34) chk("ref_halt_e34", 32'(halted), 32'h1);
      end

      // Reset from HALT: a single-cycle pulse, then identical re-run.
      run_prog(1, 10, fa, fo, fh);
      chk("rerun_acc", 32'(fa), 32'h03);
      chk("rerun_halt", 32'(fh), 32'h1);

      // Reset during T5 of LDA 6 (data 0x55): partial instruction abandoned.
      rp = vecs[0].prog;
      rp[6*8 +: 8] = 8'h55;
      load(rp);
      do_reset(2);
      for (int e = 0; e < 4; e++) step();
      chk("mid_t5", 32'(t_state), 32'h10);
      chk("mid_ce", 32'(CE_barra), 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_acc", 32'(acc), 32'h0);
      chk("mid_t", 32'(t_state), 32'h1);
      chk("mid_addr", 32'(address), 32'h0);
      chk("mid_ce_hi", 32'(CE_barra), 32'h1);
      for (int e = 0; e < 5; e++) step();
      chk("mid_restart_acc", 32'(acc), 32'h55);

      // Random programs, mostly real opcodes with random operands.
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 16; i++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel < 4)       rp[i*8 +: 8] = {4'h0, 4'($urandom)};
            else if (sel < 8)  rp[i*8 +: 8] = {4'h1, 4'($urandom)};
            else if (sel < 12) rp[i*8 +: 8] = {4'h2, 4'($urandom)};
            else if (sel < 14) rp[i*8 +: 8] = {4'hE, 4'($urandom)};
            else if (sel < 15) rp[i*8 +: 8] = {4'hF, 4'($urandom)};
            else               rp[i*8 +: 8] = 8'($urandom);
         end
         load(rp);
         run_prog($urandom_range(1, 3), 20, fa, fo, fh);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
